// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle 16-bit rotate/shift unit; define SEQ_SHIFTER_TWO_STEP_EN to shift two bits per cycle
module seq_shifter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] in,
    input  logic [1:0]  op,
    input  logic [3:0]  cnt,
    output logic        busy,
    output logic        done,
    output logic [15:0] out
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state;
    logic [15:0] data;
    logic [3:0]  rem;
    logic [1:0]  op_r;
    logic        two;
    logic        last;
    logic [3:0]  step;
    logic [15:0] s1, s2, nxt;

    // op[1] selects right vs left, op[0] selects zero fill vs wrap
    function automatic logic [15:0] shift1(input logic [15:0] d, input logic [1:0] o);
        return o[1] ? {o[0] ? 1'b0 : d[0], d[15:1]} : {d[14:0], o[0] ? 1'b0 : d[15]};
    endfunction

`ifdef SEQ_SHIFTER_TWO_STEP_EN
    assign two = rem >= 4'd2;
`else
    assign two = 1'b0;
`endif

    always_comb begin
        s1   = shift1(data, op_r);
        s2   = shift1(s1, op_r);
        nxt  = two ? s2 : s1;
        step = two ? 4'd2 : 4'd1;
        last = rem == step;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            data  <= '0;
            rem   <= '0;
            op_r  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            out   <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    data  <= in;
                    rem   <= cnt;
                    op_r  <= op;
                    busy  <= 1'b1;
                    state <= cnt == 4'd0 ? DONE : SHIFT;
                    done  <= cnt == 4'd0;
                    out   <= cnt == 4'd0 ? in : out;
                end
                SHIFT: begin
                    data  <= nxt;
                    rem   <= rem - step;
                    state <= last ? DONE : SHIFT;
                    done  <= last;
                    out   <= last ? nxt : out;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_shifter.sv
// tb_seq_shifter: directed self-checking bench for seq_shifter
module tb_seq_shifter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] in_d = '0;
    logic [1:0]  op_d = '0;
    logic [3:0]  cnt_d = '0;
    logic        busy, done;
    logic [15:0] out;
    int checks = 0;
    int errors = 0;

    seq_shifter dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in(in_d), .op(op_d),
        .cnt(cnt_d), .busy(busy), .done(done), .out(out)
    );

    always #5 clk = ~clk;

    function automatic int exp_lat(input int c);
`ifdef SEQ_SHIFTER_TWO_STEP_EN
        return (c + 1) / 2 + 1;
`else
        return c + 1;
`endif
    endfunction

    task automatic run_op(input logic [15:0] i, input logic [1:0] o, input logic [3:0] c,
                          output int lat, output logic [15:0] r);
        @(negedge clk);
        in_d = i; op_d = o; cnt_d = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        r = out;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++; if (out !== 16'h0000) begin errors++; $display("FAIL reset_out got %h want 0000", out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_rotate();
        int lat; logic [15:0] r;
        run_op(16'h8001, 2'b00, 4'd1, lat, r);
        checks++; if (r !== 16'h0003) begin errors++; $display("FAIL rotl1_out got %h want 0003", r); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL rotl1_lat got %0d want 2", lat); end
        run_op(16'h8001, 2'b10, 4'd4, lat, r);
        checks++; if (r !== 16'h1800) begin errors++; $display("FAIL rotr4_out got %h want 1800", r); end
        checks++; if (lat !== exp_lat(4)) begin errors++; $display("FAIL rotr4_lat got %0d want %0d", lat, exp_lat(4)); end
        run_op(16'h1234, 2'b10, 4'd3, lat, r);
        checks++; if (r !== 16'h8246) begin errors++; $display("FAIL rotr3_out got %h want 8246", r); end
        checks++; if (lat !== exp_lat(3)) begin errors++; $display("FAIL rotr3_lat got %0d want %0d", lat, exp_lat(3)); end
        run_op(16'h1234, 2'b00, 4'd4, lat, r);
        checks++; if (r !== 16'h2341) begin errors++; $display("FAIL rotl4_out got %h want 2341", r); end
    endtask

    task automatic test_shift();
        int lat; logic [15:0] r;
        run_op(16'hFFFF, 2'b01, 4'd15, lat, r);
        checks++; if (r !== 16'h8000) begin errors++; $display("FAIL shl15_out got %h want 8000", r); end
        checks++; if (lat !== exp_lat(15)) begin errors++; $display("FAIL shl15_lat got %0d want %0d", lat, exp_lat(15)); end
        run_op(16'hFFFF, 2'b11, 4'd15, lat, r);
        checks++; if (r !== 16'h0001) begin errors++; $display("FAIL shr15_out got %h want 0001", r); end
        checks++; if (lat !== exp_lat(15)) begin errors++; $display("FAIL shr15_lat got %0d want %0d", lat, exp_lat(15)); end
    endtask

    task automatic test_cnt0();
        @(negedge clk);
        in_d = 16'h1234; op_d = 2'b11; cnt_d = 4'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL cnt0_done got %b want 1", done); end
        checks++; if (out !== 16'h1234) begin errors++; $display("FAIL cnt0_out got %h want 1234", out); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL cnt0_busy got %b want 1", busy); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cnt0_busy_end got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL cnt0_done_end got %b want 0", done); end
    endtask

    task automatic test_back_to_back();
        int lat; logic [15:0] r;
        @(negedge clk);
        in_d = 16'h8001; op_d = 2'b10; cnt_d = 4'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        checks++; if (out !== 16'h1234) begin errors++; $display("FAIL hold_out got %h want 1234", out); end
        @(negedge clk);
        lat = 2;
        in_d = 16'hAAAA; op_d = 2'b01; cnt_d = 4'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 3;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checks++; if (out !== 16'h1800) begin errors++; $display("FAIL ignore_out got %h want 1800", out); end
        checks++; if (lat !== exp_lat(4)) begin errors++; $display("FAIL ignore_lat got %0d want %0d", lat, exp_lat(4)); end
        run_op(16'h00FF, 2'b00, 4'd2, lat, r);
        checks++; if (r !== 16'h03FC) begin errors++; $display("FAIL b2b_out got %h want 03fc", r); end
        checks++; if (lat !== exp_lat(2)) begin errors++; $display("FAIL b2b_lat got %0d want %0d", lat, exp_lat(2)); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_pulse got %b want 0", done); end
        checks++; if (out !== 16'h03FC) begin errors++; $display("FAIL b2b_hold got %h want 03fc", out); end
    endtask

    task automatic test_reset_mid();
        int lat; int pulses; logic [15:0] r;
        @(negedge clk);
        in_d = 16'h0001; op_d = 2'b01; cnt_d = 4'd10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out !== 16'h0000) begin errors++; $display("FAIL rstmid_out got %h want 0000", out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstmid_done got %b want 0", done); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL rstmid_nopulse got %0d want 0", pulses); end
        run_op(16'h0001, 2'b01, 4'd10, lat, r);
        checks++; if (r !== 16'h0400) begin errors++; $display("FAIL rstmid_next_out got %h want 0400", r); end
        checks++; if (lat !== exp_lat(10)) begin errors++; $display("FAIL rstmid_next_lat got %0d want %0d", lat, exp_lat(10)); end
    endtask

    initial begin
        test_reset();
        test_rotate();
        test_shift();
        test_cnt0();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_shifter.md
SEQ_SHIFTER -- requirements
Module: seq_shifter

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-004 SHALL have port in  input  16  operand, captured on accepted start.
REQ-005 SHALL have port op  input  2  operation, captured on accepted start: 00 rotate left, 01 shift left logical, 10 rotate right, 11 shift right logical.
REQ-006 SHALL have port cnt  input  4  shift amount 0-15, captured on accepted start.
REQ-007 SHALL have port busy  output  1  high in SHIFT and DONE states.
REQ-008 SHALL have port done  output  1  one-cycle pulse; out valid while high.
REQ-009 SHALL have port out  output  16  result register, held until next accepted start.

Function
REQ-010 SHALL implement states IDLE, SHIFT, DONE, encoded as a registered FSM.
REQ-011 SHALL, in IDLE with start=1, capture in/op/cnt at the clock edge: the data register loads in, the remaining counter loads cnt, next state is SHIFT if cnt!=0, else DONE.
REQ-012 SHALL, in each SHIFT cycle, shift the data register by one bit per op, and decrement remaining by one.
REQ-013 SHALL fill vacated bits with 0 for ops 01/11, and wrap bit 15->0 (op 00) or bit 0->15 (op 10) for rotates.
REQ-014 SHALL leave SHIFT for DONE on the edge where remaining goes from 1 to 0.
REQ-015 SHALL assert done and drive the final result on out for exactly one cycle in DONE, then return to IDLE.
REQ-016 SHALL give latency from accepted-start edge to done high of cnt+1 cycles (cnt=0 gives 1 cycle, out=in).
REQ-017 SHALL ignore start while busy=1, with no effect on state, data or counter.
REQ-018 SHALL accept a start asserted in the IDLE cycle immediately following DONE, with no dead cycle beyond the DONE cycle.
REQ-019 SHALL keep out unchanged in IDLE and SHIFT; out is updated only on entry to DONE.
REQ-020 SHALL treat op as fully decoded; no X outputs for any op/cnt combination.

Reset
REQ-021 SHALL, on rst_n low, immediately and asynchronously force state IDLE, busy=0, done=0, out=16'h0000, remaining=0, data register=0.
REQ-022 SHALL, on reset asserted mid-SHIFT or in DONE, abandon the operation with no done pulse; the first edge after release with start=1 begins a fresh operation.

Configuration
REQ-023 SHALL, with macro SEQ_SHIFTER_TWO_STEP_EN defined, shift by two bits per SHIFT cycle while remaining>=2 and by one bit when remaining==1, giving latency ceil(cnt/2)+1.
REQ-024 SHALL, without SEQ_SHIFTER_TWO_STEP_EN, shift exactly one bit per SHIFT cycle per REQ-012; results are identical in both builds, only latency differs.

Verification
REQ-025 SHALL cover: in=16'h8001, op=00, cnt=1 -> out=16'h0003, done 2 cycles after the start edge.
REQ-026 SHALL cover: in=16'h8001, op=10, cnt=4 -> out=16'h1800, done after 5 cycles (3 with TWO_STEP_EN).
REQ-027 SHALL cover: in=16'hFFFF, op=01, cnt=15 -> out=16'h8000 after 16 cycles; with op=11 -> 16'h0001.
REQ-028 SHALL cover: in=16'h1234, op=11, cnt=0 -> done next cycle, out=16'h1234, busy high for 1 cycle.
REQ-029 SHALL cover: start pulsed with in=16'hAAAA during SHIFT -> ignored; the original result is still delivered; then start in the next IDLE cycle is accepted.
REQ-030 SHALL cover: rst_n low mid-SHIFT (cnt=10, 3 cycles in) -> out=0, busy=0, done=0 with no clock edge; no done pulse; next start completes correctly.
